// File: rtl/mac_acc_multi.sv
`default_nettype none
// ============================================================================
// Module   : mac_acc_multi
// Purpose  : Multi-channel signed multiply-accumulate. Operand pairs enter via
//            a valid/ready handshake, are multiplied in a pipeline and summed
//            into one of NCH per-channel accumulators (saturate or wrap,
//            sticky overflow). A sample flagged "last" emits that channel's
//            result and restarts the channel from zero.
// Ports    : clk, n_rst          - clock, asynchronous active-low reset
//            sat_en, clr         - arithmetic mode, synchronous clear-all
//            in_valid/in_ready   - input handshake
//            in_a, in_b          - signed operands (DW bits)
//            in_ch, in_last      - target channel, end-of-frame marker
//            out_valid/out_ready - result handshake
//            out_data, out_ch    - signed result (2*DW bits) and its channel
//            out_ovf             - sticky overflow flag of the frame
// Revision : 1.0 - initial release
// ============================================================================
module mac_acc_multi #(
   parameter int DW  = 32,
   parameter int NCH = 4,
   parameter int CW  = 2
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            sat_en,
   input  logic            clr,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_a,
   input  logic [DW-1:0]   in_b,
   input  logic [CW-1:0]   in_ch,
   input  logic            in_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*DW-1:0] out_data,
   output logic [CW-1:0]   out_ch,
   output logic            out_ovf
);

   localparam int AW = 2 * DW;
   localparam logic [AW-1:0] C_MAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic [AW-1:0] C_MIN = {1'b1, {(AW-1){1'b0}}};

   // A pending, unaccepted result freezes the whole pipeline.
   logic w_stall;
   assign w_stall  = out_valid && !out_ready;
   assign in_ready = !w_stall;

   // ---------------- S1: operand capture ----------------
   logic          r_s1_v, r_s1_last, r_s1_sat;
   logic [DW-1:0] r_s1_a, r_s1_b;
   logic [CW-1:0] r_s1_ch;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_s1_v    <= 1'b0;
         r_s1_last <= 1'b0;
         r_s1_sat  <= 1'b0;
         r_s1_a    <= '0;
         r_s1_b    <= '0;
         r_s1_ch   <= '0;
      end else if (!w_stall) begin
         r_s1_v    <= in_valid;
         r_s1_last <= in_last;
         r_s1_sat  <= sat_en;
         r_s1_a    <= in_a;
         r_s1_b    <= in_b;
         r_s1_ch   <= in_ch;
      end
   end

   // ---------------- S2: full-width product ----------------
   // Operands are sign-extended to AW first; the exact product always fits.
   logic signed [AW-1:0] w_a_ext, w_b_ext, w_prod;
   assign w_a_ext = {{DW{r_s1_a[DW-1]}}, r_s1_a};
   assign w_b_ext = {{DW{r_s1_b[DW-1]}}, r_s1_b};
   assign w_prod  = w_a_ext * w_b_ext;

   logic          r_s2_v, r_s2_last, r_s2_sat;
   logic [AW-1:0] r_s2_p;
   logic [CW-1:0] r_s2_ch;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_s2_v    <= 1'b0;
         r_s2_last <= 1'b0;
         r_s2_sat  <= 1'b0;
         r_s2_p    <= '0;
         r_s2_ch   <= '0;
      end else if (!w_stall) begin
         r_s2_v    <= r_s1_v;
         r_s2_last <= r_s1_last;
         r_s2_sat  <= r_s1_sat;
         r_s2_p    <= w_prod;
         r_s2_ch   <= r_s1_ch;
      end
   end

   // ---------------- S3: read-modify-write stage ----------------
   logic          r_s3_v, r_s3_last, r_s3_sat;
   logic [AW-1:0] r_s3_p;
   logic [CW-1:0] r_s3_ch;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_s3_v    <= 1'b0;
         r_s3_last <= 1'b0;
         r_s3_sat  <= 1'b0;
         r_s3_p    <= '0;
         r_s3_ch   <= '0;
      end else if (!w_stall) begin
         r_s3_v    <= r_s2_v;
         r_s3_last <= r_s2_last;
         r_s3_sat  <= r_s2_sat;
         r_s3_p    <= r_s2_p;
         r_s3_ch   <= r_s2_ch;
      end else if (clr) begin
         // A frozen S3 sample loses to clr exactly as an unfrozen one would.
         r_s3_v    <= 1'b0;
      end
   end

   logic [AW-1:0] r_acc [NCH];
   logic [NCH-1:0] r_ovf;

   logic          w_ch_ok, w_hit, w_of;
   logic [CW-1:0] w_idx;
   logic [AW-1:0] w_acc_rd, w_res;
   logic [AW:0]   w_sum;

   // Out-of-range channels still flow through but never touch the array.
   assign w_ch_ok  = int'(r_s3_ch) < NCH;
   assign w_idx    = w_ch_ok ? r_s3_ch : '0;
   assign w_hit    = r_s3_v && w_ch_ok && !w_stall && !clr;
   assign w_acc_rd = r_acc[w_idx];

   // One guard bit: overflow whenever the top two sum bits disagree.
   assign w_sum = {w_acc_rd[AW-1], w_acc_rd} + {r_s3_p[AW-1], r_s3_p};
   assign w_of  = w_sum[AW] ^ w_sum[AW-1];

   always_comb begin
      w_res = w_sum[AW-1:0];
      if (w_of && r_s3_sat) begin
         w_res = w_sum[AW] ? C_MIN : C_MAX;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < NCH; i++) begin
            r_acc[i] <= '0;
         end
         r_ovf <= '0;
      end else if (clr) begin
         for (int i = 0; i < NCH; i++) begin
            r_acc[i] <= '0;
         end
         r_ovf <= '0;
      end else if (w_hit) begin
         if (r_s3_last) begin
            r_acc[w_idx] <= '0;
            r_ovf[w_idx] <= 1'b0;
         end else begin
            r_acc[w_idx] <= w_res;
            r_ovf[w_idx] <= r_ovf[w_idx] | w_of;
         end
      end
   end

   // Result register; w_hit already excludes the stalled case, so a pending
   // result is never overwritten.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_ovf   <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (w_hit && r_s3_last) begin
            out_valid <= 1'b1;
            out_data  <= w_res;
            out_ch    <= r_s3_ch;
            out_ovf   <= r_ovf[w_idx] | w_of;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mac_acc_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_acc_multi
// Purpose  : Directed self-checking bench for mac_acc_multi (DW=8, NCH=3 so
//            that channel 3 exercises the out-of-range path).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_acc_multi;

   localparam int DW  = 8;
   localparam int NCH = 3;
   localparam int CW  = 2;

   logic            clk = 1'b0;
   logic            n_rst;
   logic            sat_en;
   logic            clr;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_a;
   logic [DW-1:0]   in_b;
   logic [CW-1:0]   in_ch;
   logic            in_last;
   logic            out_valid;
   logic            out_ready;
   logic [2*DW-1:0] out_data;
   logic [CW-1:0]   out_ch;
   logic            out_ovf;

   int n_chk  = 0;
   int n_fail = 0;
   int n_bub  = 0;
   int cyc;

   mac_acc_multi #(.DW(DW), .NCH(NCH), .CW(CW)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .sat_en    (sat_en),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_ch     (in_ch),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One-cycle transfer; a not-ready cycle counts as an input bubble.
   task automatic send(input int a, input int b, input int ch, input bit last);
      in_valid = 1'b1;
      in_a     = 8'(a);
      in_b     = 8'(b);
      in_ch    = 2'(ch);
      in_last  = last;
      if (!in_ready) n_bub++;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Counts edges until out_valid, bounded at 20.
   task automatic wait_out(output int c);
      c = 0;
      while (!out_valid && c < 20) begin
         tick();
         c++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_rst = 1'b0; sat_en = 1'b1; clr = 1'b0; in_valid = 1'b0;
      in_a = '0; in_b = '0; in_ch = '0; in_last = 1'b0; out_ready = 1'b1;
      tick(); tick();
      n_rst = 1'b1;
      tick();

      // Reset state
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_out_ch",    out_ch,    0);
      chk("rst_out_ovf",   out_ovf,   0);

      // Basic frame on ch0: 12 - 10 + 100 = 102, latency 3 edges
      send(3, 4, 0, 0);
      send(5, -2, 0, 0);
      send(10, 10, 0, 1);
      wait_out(cyc);
      chk("b1_latency", cyc, 3);
      chk("b1_data", out_data, 102);
      chk("b1_ch",   out_ch,   0);
      chk("b1_ovf",  out_ovf,  0);
      tick();
      chk("b1_drain", out_valid, 0);
      send(1, 1, 0, 1);
      wait_out(cyc);
      chk("b1_acc_restart", out_data, 1);
      tick();

      // Positive saturation on ch1
      sat_en = 1'b1;
      repeat (3) send(127, 127, 1, 0);
      send(127, 127, 1, 1);
      wait_out(cyc);
      chk("sat_data", out_data, 16'h7FFF);
      chk("sat_ch",   out_ch,   1);
      chk("sat_ovf",  out_ovf,  1);
      tick();

      // Same frame wrapping: 64516 mod 65536
      sat_en = 1'b0;
      repeat (3) send(127, 127, 1, 0);
      send(127, 127, 1, 1);
      wait_out(cyc);
      chk("wrap_data", out_data, 16'hFC04);
      chk("wrap_ovf",  out_ovf,  1);
      tick();

      // Overflow flag cleared by the previous last
      sat_en = 1'b1;
      send(1, 1, 1, 1);
      wait_out(cyc);
      chk("ovf_restart_data", out_data, 1);
      chk("ovf_restart_ovf",  out_ovf,  0);
      tick();

      // Largest product alone is not an overflow
      send(-128, -128, 1, 1);
      wait_out(cyc);
      chk("maxprod_data", out_data, 16'h4000);
      chk("maxprod_ovf",  out_ovf,  0);
      tick();

      // Negative saturation: 3 * -16256 = -48768 -> clamp
      send(-128, 127, 0, 0);
      send(-128, 127, 0, 0);
      send(-128, 127, 0, 1);
      wait_out(cyc);
      chk("negsat_data", out_data, 16'h8000);
      chk("negsat_ovf",  out_ovf,  1);
      tick();

      // Interleaved ch0 / ch2, one sample per cycle
      send(1, 1, 0, 0);
      send(-128, -128, 2, 0);
      send(1, 1, 0, 0);
      send(-128, -128, 2, 1);
      send(1, 1, 0, 0);
      send(1, 1, 0, 1);
      chk("no_bubbles", n_bub, 0);
      wait_out(cyc);
      chk("il_ch2_data", out_data, 16'h7FFF);
      chk("il_ch2_ch",   out_ch,   2);
      chk("il_ch2_ovf",  out_ovf,  1);
      tick();
      wait_out(cyc);
      chk("il_ch0_data", out_data, 4);
      chk("il_ch0_ch",   out_ch,   0);
      chk("il_ch0_ovf",  out_ovf,  0);
      tick();

      // Back-pressure: pending result freezes the input
      out_ready = 1'b0;
      send(2, 3, 0, 1);
      wait_out(cyc);
      chk("st_first", out_data, 6);
      in_valid = 1'b1; in_a = 8'd4; in_b = 8'd5; in_ch = 2'd1; in_last = 1'b1;
      #1;
      chk("st_in_ready_low", in_ready, 0);
      tick(); tick(); tick();
      chk("st_hold_valid", out_valid, 1);
      chk("st_hold_data",  out_data,  6);
      chk("st_hold_ch",    out_ch,    0);
      chk("st_hold_ready", in_ready,  0);
      out_ready = 1'b1;
      tick();
      in_a = 8'd1; in_b = 8'(-7); in_ch = 2'd2; in_last = 1'b1;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      wait_out(cyc);
      chk("st_r1_data", out_data, 20);
      chk("st_r1_ch",   out_ch,   1);
      tick();
      chk("st_r2_valid", out_valid, 1);
      chk("st_r2_data",  out_data,  16'hFFF9);
      chk("st_r2_ch",    out_ch,    2);
      tick();
      chk("st_drain", out_valid, 0);

      // Asynchronous reset with S1..S3 occupied
      send(5, 5, 2, 0);
      send(6, 6, 2, 0);
      send(7, 7, 2, 0);
      send(8, 8, 2, 0);
      #2;
      n_rst = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_data",  out_data,  0);
      chk("ar_ch",    out_ch,    0);
      chk("ar_ovf",   out_ovf,   0);
      tick();
      n_rst = 1'b1;
      tick();
      send(1, 2, 2, 1);
      wait_out(cyc);
      chk("ar_restart_data", out_data, 2);
      chk("ar_restart_ch",   out_ch,   2);
      tick();

      // clr while a last sample sits in S3
      send(9, 9, 0, 0);
      send(2, 2, 0, 1);
      send(4, 4, 0, 0);
      send(1, 5, 0, 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_no_out", out_valid, 0);
      wait_out(cyc);
      chk("clr_latency", cyc, 2);
      chk("clr_data",    out_data, 21);
      tick();

      // Out-of-range channel is discarded
      send(5, 5, 3, 1);
      send(1, 1, 0, 1);
      wait_out(cyc);
      chk("oor_latency", cyc, 3);
      chk("oor_ch",      out_ch,   0);
      chk("oor_data",    out_data, 1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mac_acc_multi.md
Name: mac_acc_multi

Overview:
- Parametrised successor to the single-channel saturating accumulator.
- Accepts signed operand pairs with a valid/ready handshake, then multiplies them internally (pipelined).
- Accumulates each product into one of NCH independent per-channel accumulators, with selectable saturate or wrap arithmetic and a sticky overflow flag.
- Emits a channel's result when a sample marked "last" has been accumulated, then restarts that channel from zero. Sits between the sample source and the result consumer in the datapath.

Parameters:
DW, 32, signed operand width; product and accumulator width are 2*DW
NCH, 4, number of independent accumulator channels (>=1)
CW, 2, channel index width; NCH <= 2**CW

Ports:
clk  input  1  clock, all logic on rising edge
n_rst  input  1  asynchronous active-low reset
sat_en  input  1  1 = saturating accumulate, 0 = two's-complement wrap; sampled with each accepted input
clr  input  1  synchronous clear of all channel accumulators and overflow flags
in_valid  input  1  input sample valid
in_ready  output  1  block can accept a sample this cycle
in_a  input  DW  signed operand A
in_b  input  DW  signed operand B
in_ch  input  CW  target channel; values >= NCH are accepted and discarded
in_last  input  1  last sample of this channel's frame
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  2*DW  signed accumulated result
out_ch  output  CW  channel of out_data
out_ovf  output  1  sticky overflow flag of that channel's frame

Behaviour:
- Reset: all accumulators 0, all ovf flags 0, pipeline valids 0. Outputs out_valid=0, out_data=0, out_ch=0, out_ovf=0. in_ready=1 after reset. Reset mid-frame discards all in-flight samples.
- Handshake: sample transfers when in_valid && in_ready. Result transfers when out_valid && out_ready. out_data, out_ch and out_ovf stay stable while out_valid && !out_ready.
- Stall: when out_valid=1, out_ready=0 and a new result is due, the pipeline freezes. in_ready=0 during the freeze. in_ready = !(out_valid && !out_ready).
- Pipeline (no stall):
  - S1 registers operands, channel, last and mode.
  - S2 registers the full signed 2*DW-bit product.
  - S3 performs read-modify-write of acc[ch].
  - A last sample accepted at edge N gives out_valid=1 after edge N+3.
- Back-to-back samples to the same channel must accumulate correctly (S3 read/write of the same entry each cycle; no bubbles).
- Arithmetic: sum = sext(acc) + sext(product) at 2*DW+1 bits. Overflow when the top two bits differ.
  - sat_en=1: positive overflow clamps to 2^(2*DW-1)-1; negative overflow clamps to -2^(2*DW-1); ovf[ch] set.
  - sat_en=0: result is the low 2*DW bits; ovf[ch] still set on overflow.
  - A saturated accumulator keeps accumulating from the clamped value (it does not latch).
- Product -2^(DW-1) * -2^(DW-1) = 2^(2*DW-2) is representable and is not an overflow by itself.
- Last: in S3 with last=1, out_data = new sum, out_ovf = ovf[ch] | this-cycle overflow, out_valid=1. acc[ch] and ovf[ch] then reset to 0.
- clr=1: zeroes all acc and ovf at the edge. It does not cancel samples already in S1/S2, which accumulate from zero afterwards. clr and an S3 write in the same cycle: clr wins, and no result is emitted.
- in_ch >= NCH: the sample passes through the pipeline but performs no write and emits no result.

Test Plan:
- DW=8, ch0: (3,4),(5,-2),(10,10,last) -> out_valid 3 cycles after last accept, out_data=102, out_ch=0, out_ovf=0, acc0 back to 0.
- DW=8, sat_en=1, ch1: 3 x (127,127) then (127,127,last) (16129 each) -> out_data=32767, out_ovf=1. Same frame with sat_en=0 -> out_data=0xFC04 (64516 mod 65536), out_ovf=1.
- DW=8, interleaved ch0/ch2 every cycle, ch0: (1,1)x4 last, ch2: (-128,-128)x2 last -> ch0 out 4, ch2 out 32767 with ovf=1 (sat); zero bubbles on input.
- Hold out_ready=0 with a result pending, then present two more last samples -> in_ready drops, out_data stable, no sample lost; release -> results emitted in order.
- Pulse n_rst low mid-frame with samples in S1–S3 -> all outputs 0 immediately; the next frame on the same channel starts from 0.
- Assert clr while in_last is in S3 -> no out_valid; the S1/S2 samples accumulate from 0.
